// File: rtl/packet_sink_monitor_64.sv
// Observation end of the NoC packet-injection loop: waits for the first flagged packet after arm
// and latches payload, router index, latency and hit count, with seven-segment readout.
module packet_sink_monitor_64 #(
    parameter int NUM_ROUTERS = 64,
    parameter int PKT_W       = 15,
    parameter int IDX_W       = 6,
    parameter int LAT_W       = 16,
    parameter int TIMEOUT     = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_ROUTERS*PKT_W-1:0] in_packets,
    input  logic                         arm,
    input  logic                         clear,
    output logic                         pkt_valid,
    output logic [PKT_W-2:0]             pkt_data,
    output logic [IDX_W-1:0]             pkt_router,
    output logic [LAT_W-1:0]             pkt_latency,
    output logic [6:0]                   hit_count,
    output logic                         timeout,
    output logic [6:0]                   hex_router_hi,
    output logic [6:0]                   hex_router_lo,
    output logic [6:0]                   hex_data
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURED, S_TIMEOUT} state_t;

    localparam logic [6:0] HEX_BLANK = 7'b1111111;
    localparam logic [6:0] HEX_DASH  = 7'b1111110;

    state_t            state, state_next;
    logic              arm_q, arm_rise;
    logic              has_result, has_result_next;
    logic [LAT_W-1:0]  lat_cnt, lat_next, lat_sat;
    logic [31:0]       lat_inc32;
    logic [PKT_W-2:0]  data_next, first_data;
    logic [IDX_W-1:0]  router_next, first_idx;
    logic [LAT_W-1:0]  latency_next;
    logic [6:0]        hits_next, hits;
    logic              any_hit;
    logic [6:0]        hex_hi_next, hex_lo_next, hex_data_next;

    // Active-low segments, a at bit 6 through g at bit 0.
    function automatic logic [6:0] seg_hex(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0: on = 7'b1111110;  4'h1: on = 7'b0110000;
            4'h2: on = 7'b1101101;  4'h3: on = 7'b1111001;
            4'h4: on = 7'b0110011;  4'h5: on = 7'b1011011;
            4'h6: on = 7'b1011111;  4'h7: on = 7'b1110000;
            4'h8: on = 7'b1111111;  4'h9: on = 7'b1111011;
            4'hA: on = 7'b1110111;  4'hB: on = 7'b0011111;
            4'hC: on = 7'b1001110;  4'hD: on = 7'b0111101;
            4'hE: on = 7'b1001111;  default: on = 7'b1000111;
        endcase
        return ~on;
    endfunction

    assign arm_rise  = arm & ~arm_q;
    assign lat_inc32 = 32'(lat_cnt) + 32'd1;
    assign lat_sat   = (&lat_cnt) ? lat_cnt : lat_cnt + LAT_W'(1);

    // Walk from the top down so the lowest flagged router is the one left standing.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        first_idx  = '0;
        first_data = '0;
        hits       = '0;
        for (int i = NUM_ROUTERS - 1; i >= 0; i--) begin
            if (in_packets[i*PKT_W + PKT_W - 1]) begin
                first_idx  = IDX_W'(i);
                first_data = in_packets[i*PKT_W +: PKT_W-1];
                hits       = hits + 7'd1;
            end
        end
        any_hit = (hits != 7'd0);
    end

    always_comb begin
        state_next      = state;
        lat_next        = lat_cnt;
        data_next       = pkt_data;
        router_next     = pkt_router;
        latency_next    = pkt_latency;
        hits_next       = hit_count;
        has_result_next = has_result;

        if (clear) begin
            state_next      = S_IDLE;
            lat_next        = '0;
            data_next       = '0;
            router_next     = '0;
            latency_next    = '0;
            hits_next       = '0;
            has_result_next = 1'b0;
        end else begin
            case (state)
                S_IDLE: if (arm_rise) begin
                    state_next      = S_ARMED;
                    lat_next        = '0;
                    data_next       = '0;
                    router_next     = '0;
                    latency_next    = '0;
                    hits_next       = '0;
                    has_result_next = 1'b0;
                end
                S_ARMED: begin
                    if (any_hit) begin
                        state_next      = S_CAPTURED;
                        data_next       = first_data;
                        router_next     = first_idx;
                        latency_next    = lat_sat;
                        hits_next       = hits;
                        has_result_next = 1'b1;
                    end else if (lat_inc32 == 32'(TIMEOUT)) begin
                        state_next = S_TIMEOUT;
                    end else begin
                        lat_next = lat_sat;
                    end
                end
                S_CAPTURED: if (!arm) state_next = S_IDLE;
                default:    if (!arm) state_next = S_IDLE;
            endcase
        end

        // Displays are driven from next-state values so they register alongside the fields.
        if (state_next == S_TIMEOUT) begin
            hex_hi_next   = HEX_DASH;
            hex_lo_next   = HEX_DASH;
            hex_data_next = HEX_DASH;
        end else if (has_result_next) begin
            hex_hi_next   = seg_hex({2'b00, router_next[5:4]});
            hex_lo_next   = seg_hex(router_next[3:0]);
            hex_data_next = seg_hex(data_next[3:0]);
        end else begin
            hex_hi_next   = HEX_BLANK;
            hex_lo_next   = HEX_BLANK;
            hex_data_next = HEX_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            arm_q         <= 1'b0;
            has_result    <= 1'b0;
            lat_cnt       <= '0;
            pkt_valid     <= 1'b0;
            pkt_data      <= '0;
            pkt_router    <= '0;
            pkt_latency   <= '0;
            hit_count     <= '0;
            timeout       <= 1'b0;
            hex_router_hi <= HEX_BLANK;
            hex_router_lo <= HEX_BLANK;
            hex_data      <= HEX_BLANK;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state         <= state_next;
            arm_q         <= arm;
            has_result    <= has_result_next;
            lat_cnt       <= lat_next;
            pkt_valid     <= (state_next == S_CAPTURED);
            pkt_data      <= data_next;
            pkt_router    <= router_next;
            pkt_latency   <= latency_next;
            hit_count     <= hits_next;
            timeout       <= (state_next == S_TIMEOUT);
            hex_router_hi <= hex_hi_next;
            hex_router_lo <= hex_lo_next;
            hex_data      <= hex_data_next;
        end
    end

endmodule

// File: tb/tb_packet_sink_monitor_64.sv
// Directed bench for packet_sink_monitor_64: stimulus pushes expected captures/timeouts into a
// scoreboard queue, a negedge monitor pops them as pkt_valid or timeout rises.
module tb_packet_sink_monitor_64;

    localparam int NR = 64;
    localparam int PW = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*PW-1:0]  in_packets;
    logic              arm, clear;
    logic              pkt_valid, timeout;
    logic [13:0]       pkt_data;
    logic [5:0]        pkt_router;
    logic [15:0]       pkt_latency;
    logic [6:0]        hit_count, hex_router_hi, hex_router_lo, hex_data;

    packet_sink_monitor_64 #(.TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .in_packets(in_packets), .arm(arm), .clear(clear),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_router(pkt_router),
        .pkt_latency(pkt_latency), .hit_count(hit_count), .timeout(timeout),
        .hex_router_hi(hex_router_hi), .hex_router_lo(hex_router_lo), .hex_data(hex_data)
    );

    always #5 clk = ~clk;

    // Lit-segment patterns, a at bit 6 .. g at bit 0; displays are the inverse.
    localparam logic [6:0] SEG_ON [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b1111110;

    typedef struct {
        bit         is_timeout;
        logic [5:0] router;
        logic [13:0] data;
        logic [15:0] lat;
        logic [6:0] hits;
        logic [6:0] hh, hl, hd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] hx(input logic [3:0] v);
        return ~SEG_ON[v];
    endfunction

    task automatic push_cap(input logic [5:0] r, input logic [13:0] d, input logic [15:0] l,
                            input logic [6:0] h);
        exp_t e;
        e.is_timeout = 1'b0; e.router = r; e.data = d; e.lat = l; e.hits = h;
        e.hh = hx({2'b00, r[5:4]}); e.hl = hx(r[3:0]); e.hd = hx(d[3:0]);
        exp_q.push_back(e);
    endtask

    task automatic push_timeout();
        exp_t e;
        e.is_timeout = 1'b1; e.router = '0; e.data = '0; e.lat = '0; e.hits = '0;
        e.hh = DASH; e.hl = DASH; e.hd = DASH;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int i, input logic [14:0] v);
        in_packets[i*PW +: PW] = v;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'(pkt_valid), 0);
        check({tag, "_router"}, 32'(pkt_router), 0);
        check({tag, "_data"}, 32'(pkt_data), 0);
        check({tag, "_lat"}, 32'(pkt_latency), 0);
        check({tag, "_hits"}, 32'(hit_count), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_hex"}, {11'd0, hex_router_hi, hex_router_lo, hex_data},
              {11'd0, BLANK, BLANK, BLANK});
    endtask

    // Monitor: compare against the scoreboard on each rising pkt_valid / timeout.
    logic prev_valid = 1'b0;
    logic prev_to = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ((pkt_valid && !prev_valid) || (timeout && !prev_to)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {30'd0, pkt_valid, timeout}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("mon_kind", 32'(timeout), 32'(e.is_timeout));
                    check("mon_valid", 32'(pkt_valid), 32'(!e.is_timeout));
                    if (!e.is_timeout) begin
                        check("mon_router", 32'(pkt_router), 32'(e.router));
                        check("mon_data", 32'(pkt_data), 32'(e.data));
                        check("mon_latency", 32'(pkt_latency), 32'(e.lat));
                        check("mon_hits", 32'(hit_count), 32'(e.hits));
                    end
                    check("mon_hex_hi", 32'(hex_router_hi), 32'(e.hh));
                    check("mon_hex_lo", 32'(hex_router_lo), 32'(e.hl));
                    check("mon_hex_data", 32'(hex_data), 32'(e.hd));
                end
            end
        end
        prev_valid = pkt_valid;
        prev_to    = timeout;
    end

    initial begin
        rst_n = 1'b0; arm = 1'b0; clear = 1'b0; in_packets = '0;
        tick(2);
        check_cleared("reset_init");
        rst_n = 1'b1;
        tick(1);

        // First capture: router 37 after 5 empty ARMED samples.
        arm = 1'b1;
        tick(1);
        tick(5);
        set_pkt(37, 15'h4123);
        push_cap(6'd37, 14'h0123, 16'd6, 7'd1);
        tick(1);
        in_packets = '0;
        tick(1);

        // Later packet while CAPTURED is ignored.
        set_pkt(5, 15'h4777);
        tick(3);
        in_packets = '0;
        check("hold_valid", 32'(pkt_valid), 1);
        check("hold_router", 32'(pkt_router), 37);
        check("hold_data", 32'(pkt_data), 32'h0123);
        check("hold_lat", 32'(pkt_latency), 6);
        check("hold_hits", 32'(hit_count), 1);

        // Drop arm: result retained in IDLE.
        arm = 1'b0;
        tick(1);
        check("idle_valid", 32'(pkt_valid), 0);
        check("idle_router", 32'(pkt_router), 37);
        check("idle_hex_lo", 32'(hex_router_lo), 32'(hx(4'h5)));

        // Re-arm: fields and display cleared, latency restarts.
        arm = 1'b1;
        tick(1);
        check("rearm_router", 32'(pkt_router), 0);
        check("rearm_hex_lo", 32'(hex_router_lo), 32'(BLANK));
        set_pkt(9, 15'h40AB);
        push_cap(6'd9, 14'h00AB, 16'd1, 7'd1);
        tick(1);
        in_packets = '0;
        tick(1);

        // Clear in CAPTURED with arm held high: no re-arm even with traffic.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_cleared("clear");
        set_pkt(1, 15'h4011);
        tick(3);
        in_packets = '0;
        check("noarm_valid", 32'(pkt_valid), 0);
        check("noarm_router", 32'(pkt_router), 0);

        // Simultaneous hits: lowest index wins, popcount 3.
        arm = 1'b0;
        tick(1);
        arm = 1'b1;
        tick(1);
        set_pkt(12, 15'h4001);
        set_pkt(40, 15'h4002);
        set_pkt(63, 15'h4003);
        push_cap(6'd12, 14'h0001, 16'd1, 7'd3);
        tick(1);
        in_packets = '0;
        tick(1);

        // Timeout after exactly 20 ARMED samples.
        arm = 1'b0;
        tick(1);
        arm = 1'b1;
        tick(1);
        push_timeout();
        tick(19);
        check("timeout_early", 32'(timeout), 0);
        tick(1);
        check("timeout_set", 32'(timeout), 1);
        check("timeout_hex", {11'd0, hex_router_hi, hex_router_lo, hex_data},
              {11'd0, DASH, DASH, DASH});
        arm = 1'b0;
        tick(1);
        check_cleared("timeout_exit");

        // Async reset mid-ARMED with a packet on the bus, then held across edges.
        arm = 1'b1;
        tick(1);
        set_pkt(50, 15'h4005);
        #2 rst_n = 1'b0;
        #1 check_cleared("rst_armed");
        tick(2);
        check_cleared("rst_held");
        arm = 1'b0;
        rst_n = 1'b1;
        in_packets = '0;
        tick(1);

        // Async reset out of CAPTURED clears results with no clock edge.
        arm = 1'b1;
        tick(1);
        set_pkt(50, 15'h4005);
        push_cap(6'd50, 14'h0005, 16'd1, 7'd1);
        tick(1);
        in_packets = '0;
        tick(1);
        #2 rst_n = 1'b0;
        #1 check_cleared("rst_captured");

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_sink_monitor_64.md
Name: packet_sink_monitor_64

Overview:
- Sits directly downstream of the 64-router NoC mesh and consumes the 15-bit local-port output of every router.
- After the operator arms it, it waits for the first emulated packet delivered by the network. It captures the packet payload, the index of the receiving router, the delivery latency in clock cycles, and the number of routers that delivered in the same cycle.
- Results are shown on seven-segment displays.
- It is the observation end of the board-level packet-injection test loop.

Parameters:
NUM_ROUTERS, 64, number of router local outputs monitored
PKT_W, 15, packet width; bit PKT_W-1 is the valid/emulation flag, bits PKT_W-2:0 are payload
IDX_W, 6, width of the router index
LAT_W, 16, width of the latency counter
TIMEOUT, 50000, ARMED cycles without delivery before the block declares TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_packets  in  NUM_ROUTERS*PKT_W  router local outputs, router i at bits [i*PKT_W+PKT_W-1 : i*PKT_W]
arm  in  1  operator switch; a rising edge starts a measurement
clear  in  1  synchronous clear, returns the block to IDLE
pkt_valid  out  1  high while in CAPTURED
pkt_data  out  PKT_W-1  captured payload
pkt_router  out  IDX_W  index of the capturing router
pkt_latency  out  LAT_W  cycles from arm to delivery
hit_count  out  7  number of routers with the valid flag set on the capture cycle
timeout  out  1  high while in TIMEOUT
hex_router_hi  out  7  pkt_router[5:4] as a hex digit, active-low, segments a..g at bits 6..0
hex_router_lo  out  7  pkt_router[3:0] as a hex digit
hex_data  out  7  pkt_data[3:0] as a hex digit

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; arm_q=0.
  - lat_cnt, pkt_valid, pkt_data, pkt_router, pkt_latency, hit_count and timeout all 0.
  - All hex outputs 7'b1111111 (blank).
- arm is registered into arm_q each cycle. arm_rise = arm & ~arm_q.
- clear has priority over everything except reset:
  - state goes to IDLE and all captured registers go to 0.
  - arm_q still updates.
- IDLE: on arm_rise, go to ARMED and set lat_cnt=0. Captured registers are zeroed on the same edge.
- ARMED, sampled every edge:
  - If any valid flag in in_packets is 1, go to CAPTURED on that edge and capture:
    - pkt_router = lowest index i with the valid flag set;
    - pkt_data = that router's bits PKT_W-2:0;
    - pkt_latency = lat_cnt+1, saturating at 2^LAT_W-1;
    - hit_count = popcount of all 64 valid flags.
  - Else if lat_cnt+1 == TIMEOUT, go to TIMEOUT.
  - Else lat_cnt increments, saturating.
  - If a packet arrives on the very first ARMED sample, pkt_latency=1.
- CAPTURED: pkt_valid=1. Outputs hold and later packets are ignored. When arm==0, go to IDLE with outputs retained (pkt_valid drops).
- TIMEOUT: timeout=1. When arm==0, go to IDLE.
- Results from a previous run stay visible in IDLE until the next arm_rise or clear.
- arm held high across a CAPTURED or TIMEOUT→IDLE transition does not re-arm; only a fresh rising edge does.
- Hex displays:
  - IDLE with no prior capture, and ARMED: blank.
  - CAPTURED or retained result: hex digit of the field, using the table 0=~7'b1111110 ... F=~7'b1000111.
  - TIMEOUT: all three displays show a dash, 7'b1111110.
- Latency: in_packets to capture is 1 clock edge. All outputs are registered.

Test Plan:
1. Reset mid-ARMED with a packet present → all outputs 0, hex blank immediately, with no clock needed.
2. arm rises; 5 cycles after the ARMED entry, router 37 presents 15'h4123 → pkt_valid=1, pkt_router=37, pkt_data=14'h0123, pkt_latency=6, hit_count=1, hex_router_hi=2, hex_router_lo=5, hex_data=3.
3. Routers 12, 40 and 63 all valid in the same cycle, with payloads 1, 2, 3 → pkt_router=12, pkt_data=1, hit_count=3.
4. TIMEOUT overridden to 20, no packets → timeout=1 exactly 20 ARMED cycles after entry, all hex show dash. Dropping arm → IDLE, timeout=0.
5. After a capture, router 5 sends again while still CAPTURED → outputs unchanged. Dropping then raising arm → new run, lat_cnt restarts at 0.
6. clear asserted in CAPTURED → state IDLE, pkt_valid=0, pkt_router=0, hex blank next edge. arm held high throughout → no re-arm.
